// File: rtl/mux_scan_seq.sv
// Round-robin channel scanner feeding a 4-to-1 mux.
//
// The scanner drives sel, waits DWELL cycles for the selected input to settle,
// and then captures mux_in. Each sample leaves on a valid/ready stream together
// with its channel number. Channels whose ch_mask bit is clear are skipped.
//
// Build option MUX_SCAN_OVERRUN_EN:
//   undefined - the scanner stalls in HOLD until the sample is accepted.
//               overrun is tied to 0.
//   defined   - free-running scan with no HOLD state. An unaccepted sample is
//               overwritten by the next capture, which sets the sticky overrun
//               flag.
module mux_scan_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    ch_mask,
  output logic [1:0]    sel,
  input  logic [DW-1:0] mux_in,
  output logic [DW-1:0] data_out,
  output logic [1:0]    ch_out,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

  // Settle count at which the capture happens. sel is stable for counts 0..DWELL-1.
  localparam logic [7:0] CntLast = 8'(DWELL - 1);

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [1:0]      ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  logic            mask_any;
  logic            handshake;

  // Return the first enabled channel at or after p (inclusive search), or after
  // p (exclusive search), wrapping from 3 back to 0. If no channel is enabled,
  // p is returned unchanged.
  function automatic logic [1:0] nxt(input logic [1:0] p, input logic [3:0] m,
                                     input logic incl);
    logic [1:0] res;
    logic [1:0] c;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = p + 2'(i) + (incl ? 2'd0 : 2'd1);
      if (!found && m[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign mask_any  = |ch_mask;
  assign handshake = valid_q & ready;

  // Next-state logic: scan sequencing, sample capture and stream handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    // An accepted sample leaves the stream. A capture on the same edge
    // overrides this below, so a new sample replaces the accepted one.
    if (handshake) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // ch_mask is sampled only here and at the advance after a capture.
        if (en && mask_any) begin
          sel_d   = nxt(sel_q, ch_mask, 1'b1);
          cnt_d   = '0;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (!en) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          data_d  = mux_in;
          ch_d    = sel_q;
          valid_d = 1'b1;
`ifdef MUX_SCAN_OVERRUN_EN
          // The previous sample is still pending and is not taken on this
          // edge, so it is lost.
          if (valid_q && !ready) begin
            ovr_d = 1'b1;
          end
          if (mask_any) begin
            sel_d = nxt(sel_q, ch_mask, 1'b0);
            cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StHold;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StHold: begin
`ifndef MUX_SCAN_OVERRUN_EN
        // valid is always set in HOLD. Without ready, every output stays frozen.
        if (ready) begin
          if (en && mask_any) begin
            sel_d   = nxt(sel_q, ch_mask, 1'b0);
            cnt_d   = '0;
            state_d = StSettle;
          end else begin
            state_d = StIdle;
          end
        end
`else
        state_d = StIdle;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset. Reset discards any pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign ch_out   = ch_q;
  assign valid    = valid_q;
  assign busy     = (state_q != StIdle);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq. A behavioural 4-to-1 mux feeds mux_in.
// Expected samples come from a channel-order model built directly from the
// scan rules. Honours MUX_SCAN_OVERRUN_EN in the same way as the design.
module tb_mux_scan_seq;

  localparam int DW    = 8;
  localparam int DWELL = 4;
`ifdef MUX_SCAN_OVERRUN_EN
  localparam int GAP = DWELL;       // free-running: a capture every DWELL edges
`else
  localparam int GAP = DWELL + 1;   // one extra edge spent in HOLD for the handshake
`endif

  logic          clk = 1'b0;
  logic          rst, en, ready;
  logic [3:0]    ch_mask;
  logic [1:0]    sel, ch_out;
  logic [DW-1:0] mux_in, data_out;
  logic          valid, busy, overrun;
  logic [DW-1:0] in_val [4];

  int n_cmp = 0;
  int n_err = 0;

  mux_scan_seq #(.DW(DW), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_mask  (ch_mask),
    .sel      (sel),
    .mux_in   (mux_in),
    .data_out (data_out),
    .ch_out   (ch_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Behavioural stand-in for mux4a1
  assign mux_in = in_val[sel];

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the first enabled channel when searching from p (inclusive) or p+1 (exclusive)
  function automatic logic [1:0] ref_next(input logic [1:0] p, input logic [3:0] m,
                                          input bit incl);
    int start;
    start = incl ? int'(p) : int'(p) + 1;
    for (int k = 0; k < 4; k++) begin
      if (m[(start + k) % 4]) return 2'((start + k) % 4);
    end
    return p;
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; ch_mask = 4'h0;
    in_val[0] = 8'h11; in_val[1] = 8'h22; in_val[2] = 8'h33; in_val[3] = 8'h44;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait for valid. lat is the number of edges taken, or 0 if the budget ran out.
  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; en = 1'b1; ch_mask = 4'hf; ready = 1'b1;
    in_val[0] = 8'h11; in_val[1] = 8'h22; in_val[2] = 8'h33; in_val[3] = 8'h44;
    repeat (3) step();
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", data_out); end
    n_cmp++; if (ch_out !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d expected 0", ch_out); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    wait_valid(20, lat);
    n_cmp++; if (lat != DWELL + 1) begin n_err++; $display("FAIL reset_latency: got %0d expected %0d", lat, DWELL + 1); end
    n_cmp++; if (data_out !== 8'h11 || ch_out !== 2'd0) begin
      n_err++; $display("FAIL first_sample: got (%0d,%0h) expected (0,11)", ch_out, data_out);
    end
  endtask

  // Scan with ready held at 1: checks sample order, data, pulse width and spacing
  task automatic test_scan(input logic [3:0] mask, input int nsamp);
    int t, last_t, got;
    logic [1:0] p, exp_ch;
    bit first;
    logic prev_valid;
    do_reset();
    en = 1'b1; ch_mask = mask; ready = 1'b1;
    t = 0; last_t = -1; got = 0; p = 2'd0; first = 1'b1; prev_valid = 1'b0;
    while (got < nsamp && t < 30 * nsamp) begin
      step();
      t++;
      if (valid) begin
        exp_ch = ref_next(p, mask, first);
        first = 1'b0;
        p = exp_ch;
        n_cmp++; if (ch_out !== exp_ch || data_out !== in_val[exp_ch]) begin
          n_err++;
          $display("FAIL scan_sample[%0d] mask=%b: got (%0d,%0h) expected (%0d,%0h)",
                   got, mask, ch_out, data_out, exp_ch, in_val[exp_ch]);
        end
        n_cmp++; if (prev_valid !== 1'b0) begin
          n_err++; $display("FAIL scan_pulse_width[%0d]: valid high 2+ cycles, expected 1", got);
        end
        if (last_t >= 0) begin
          n_cmp++; if (t - last_t != GAP) begin
            n_err++; $display("FAIL scan_spacing[%0d]: got %0d expected %0d", got, t - last_t, GAP);
          end
        end
        last_t = t;
        got++;
      end
      prev_valid = valid;
    end
    n_cmp++; if (got != nsamp) begin n_err++; $display("FAIL scan_count mask=%b: got %0d expected %0d", mask, got, nsamp); end
  endtask

  task automatic test_mask_zero();
    do_reset();
    en = 1'b1; ch_mask = 4'h0; ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin
        n_err++; $display("FAIL mask_zero_idle[%0d]: got busy=%b valid=%b expected 0/0", k, busy, valid);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    en = 1'b1; ch_mask = 4'hf; ready = 1'b1;
    repeat (3) step();          // SETTLE with count 2
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    en = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL abort_no_valid[%0d]: got %b expected 0", k, valid); end
      step();
    end
  endtask

  task automatic test_reset_in_hold();
    int lat;
    do_reset();
    en = 1'b1; ch_mask = 4'b0100; ready = 1'b0;
    wait_valid(20, lat);
    n_cmp++; if (lat == 0 || ch_out !== 2'd2 || data_out !== 8'h33) begin
      n_err++; $display("FAIL hold_sample: got lat=%0d (%0d,%0h) expected (2,33)", lat, ch_out, data_out);
    end
    rst = 1'b1;
    step();
    n_cmp++; if (valid !== 1'b0 || sel !== 2'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_in_hold: got valid=%b sel=%0d busy=%b expected 0/0/0", valid, sel, busy);
    end
    rst = 1'b0;
  endtask

`ifndef MUX_SCAN_OVERRUN_EN
  task automatic test_backpressure();
    int lat;
    do_reset();
    en = 1'b1; ch_mask = 4'hf; ready = 1'b0;
    wait_valid(20, lat);
    n_cmp++; if (lat == 0) begin n_err++; $display("FAIL bp_first_valid: got timeout expected valid"); end
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if (valid !== 1'b1 || data_out !== 8'h11 || ch_out !== 2'd0 || sel !== 2'd0) begin
        n_err++;
        $display("FAIL bp_frozen[%0d]: got v=%b d=%0h ch=%0d sel=%0d expected 1/11/0/0",
                 k, valid, data_out, ch_out, sel);
      end
    end
    ready = 1'b1;
    step();
    n_cmp++; if (valid !== 1'b0 || sel !== 2'd1) begin
      n_err++; $display("FAIL bp_release: got valid=%b sel=%0d expected 0/1", valid, sel);
    end
  endtask
`else
  task automatic test_overrun();
    int lat;
    do_reset();
    en = 1'b1; ch_mask = 4'hf; ready = 1'b0;
    wait_valid(20, lat);
    n_cmp++; if (lat == 0 || overrun !== 1'b0 || data_out !== 8'h11) begin
      n_err++; $display("FAIL ovr_first: got lat=%0d ovr=%b d=%0h expected ovr=0 d=11", lat, overrun, data_out);
    end
    repeat (DWELL) step();
    n_cmp++; if (overrun !== 1'b1 || data_out !== 8'h22 || ch_out !== 2'd1 || valid !== 1'b1) begin
      n_err++; $display("FAIL ovr_second: got ovr=%b d=%0h ch=%0d v=%b expected 1/22/1/1",
                        overrun, data_out, ch_out, valid);
    end
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky[%0d]: got %b expected 1", k, overrun); end
    end
    rst = 1'b1;
    step();
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    rst = 1'b0;
  endtask

  task automatic test_coincident();
    int lat;
    do_reset();
    en = 1'b1; ch_mask = 4'hf; ready = 1'b0;
    wait_valid(20, lat);
    repeat (DWELL - 1) step();
    ready = 1'b1;               // accept on the same edge as the next capture
    step();
    n_cmp++; if (valid !== 1'b1 || data_out !== 8'h22 || overrun !== 1'b0) begin
      n_err++; $display("FAIL coincident: got v=%b d=%0h ovr=%b expected 1/22/0", valid, data_out, overrun);
    end
    ready = 1'b0;
  endtask
`endif

  // Random masks, data and (in the stalling build) random ready
  task automatic test_random_scan();
    for (int seg = 0; seg < 6; seg++) begin
      int got, t;
      logic [1:0] p, exp_ch, held_ch;
      logic [DW-1:0] held_d;
      bit first, held;
      logic [3:0] mask;
      do_reset();
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) in_val[c] = 8'($urandom);
      en = 1'b1; ch_mask = mask;
      got = 0; t = 0; p = 2'd0; first = 1'b1; held = 1'b0;
      while (got < 8 && t < 400) begin
`ifdef MUX_SCAN_OVERRUN_EN
        ready = 1'b1;
`else
        ready = 1'($urandom_range(0, 1));
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL no_overrun: got %b expected 0", overrun); end
`endif
        if (held) begin
          n_cmp++; if (valid !== 1'b1 || data_out !== held_d || ch_out !== held_ch) begin
            n_err++; $display("FAIL rnd_frozen: got (%0d,%0h) v=%b expected (%0d,%0h) v=1",
                              ch_out, data_out, valid, held_ch, held_d);
          end
        end
        held = 1'b0;
        if (valid && ready) begin
          exp_ch = ref_next(p, mask, first);
          first = 1'b0;
          p = exp_ch;
          n_cmp++; if (ch_out !== exp_ch || data_out !== in_val[exp_ch]) begin
            n_err++; $display("FAIL rnd_sample seg=%0d #%0d mask=%b: got (%0d,%0h) expected (%0d,%0h)",
                              seg, got, mask, ch_out, data_out, exp_ch, in_val[exp_ch]);
          end
          got++;
        end else if (valid) begin
          held = 1'b1; held_d = data_out; held_ch = ch_out;
        end
        step();
        t++;
      end
      n_cmp++; if (got != 8) begin n_err++; $display("FAIL rnd_count seg=%0d: got %0d expected 8", seg, got); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; ch_mask = 4'h0;
    in_val[0] = 8'h11; in_val[1] = 8'h22; in_val[2] = 8'h33; in_val[3] = 8'h44;
    test_reset();
    test_scan(4'b1111, 5);
    test_scan(4'b1010, 4);
    test_mask_zero();
    test_abort();
    test_reset_in_hold();
`ifndef MUX_SCAN_OVERRUN_EN
    test_backpressure();
`else
    test_overrun();
    test_coincident();
`endif
    test_random_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
